pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

Parametrised hazard and forwarding controller for the pipelined CPU core. It tracks every in-flight register write in the stages after decode (EX, MEM, WB by default) with a valid/rd/load scoreboard. It detects load-use hazards and asserts a stall that holds PC and IF_ID while a bubble enters ID_EX. For every other RAW dependency it produces registered forwarding selects for the EX-stage ALU operand muxes. Stage count, register-address width and load-result stage are parameters, so the same block serves deeper pipeline generations.

## Interface
- REG_ADDR_W, 5, register address width
- STAGES, 3, tracked stages after ID; stage 0 = EX, STAGES-1 = WB
- LOAD_RESULT_STAGE, 1, stage whose end produces load data (1 = MEM); range 0..STAGES-1
- FWD_W, $clog2(STAGES+1), forwarding-select width
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset; **one clock; reset is synchronous and active-high**
- start_i  in  1  advance enable; low = scoreboard and selects frozen
- id_valid_i  in  1  ID holds a real instruction
- id_rs_i, id_rt_i  in  REG_ADDR_W each  source registers of ID instruction
- id_uses_rs_i, id_uses_rt_i  in  1 each  source actually read
- id_regwrite_i  in  1  ID instruction writes a register
- id_rd_i  in  REG_ADDR_W  destination of ID instruction (already RegDst-muxed)
- id_memtoreg_i  in  1  ID instruction is a load
- flush_i  in  1  kill ID instruction (taken branch/jump resolved in ID)
- stall_o  out  1  combinational; hold PC and IF_ID, insert bubble
- fwd_rs_o, fwd_rt_o  out  FWD_W each  registered; 0 = register-file operand, k = result of stage k
- stage_valid_o  out  STAGES  per-stage valid
- stage_regwrite_o  out  STAGES  per-stage write enable, qualified by valid
- stage_rd_o  out  STAGES*REG_ADDR_W  per-stage destination, stage 0 in LSBs

## Operation
- Scoreboard entry per stage: {valid, regwrite, rd, is_load}. rd==0 stored with regwrite=0, so register 0 is never a hazard.
- Match search for each used, nonzero source: youngest stage k (lowest index) with valid & regwrite & rd==src. Younger matches take priority.
- Load-use: a match at stage k with is_load and k+1 <= LOAD_RESULT_STAGE → stall_o=1. Default: load in EX and dependent instruction in ID → one stall cycle.
- stall_o = id_valid_i & ~flush_i & (hazard on rs | hazard on rt). Flush overrides stall.
- Forward select, next cycle's EX operand: match at k with k+1 < STAGES → select k+1. Match only at last stage → select 0; the register file is write-before-read and supplies the value.
- Advance (start_i=1, rst_i=0): stage[k] <= stage[k-1] for k>=1.
  - stage[0] <= ID entry if id_valid_i & ~stall_o & ~flush_i, else a bubble (all fields 0).
  - fwd_rs_o/fwd_rt_o load the computed selects; for a bubble they load 0.
- start_i=0: no state change; stall_o is still computed from current state.

## Timing
- Reset: all stage_valid_o, stage_regwrite_o, stage_rd_o, fwd_rs_o, fwd_rt_o = 0 after the first edge with rst_i=1. stall_o = 0 then, since no entries are valid.
- Reset mid-operation: all in-flight entries are discarded at that edge. Reset has priority over start_i and flush_i.
- Scoreboard latency: one cycle from ID to stage 0. An entry leaves the scoreboard STAGES cycles after issue.
- Forward selects are valid in the cycle the consumer sits in EX (stage 0).
- Stall duration: LOAD_RESULT_STAGE-k cycles for a load at stage k. stall_o deasserts combinationally in the cycle the load reaches stage LOAD_RESULT_STAGE.
- Flush and stall in the same cycle: bubble inserted, stall_o=0, and the PC takes the redirect.
- Bubble cycles are not counted as issue.

## Test plan
- Back-to-back ALU RAW (defaults): add r3 in ID, then sub using r3 next cycle → no stall; fwd_rs_o=1 with sub in EX. One gap cycle → fwd=2. Two gap cycles → fwd=0.
- Load-use: lw r4 then add r5,r4,r4 → stall_o=1 for exactly 1 cycle; stage_valid_o[0]=0 bubble; add reaches EX with fwd_rs_o=fwd_rt_o=2.
- Priority: add r2 then lw r2 then use r2 one cycle after lw issue → stall 1 cycle; select points at the load's stage, not the older add.
- r0 and unused sources: producer writes r0, or consumer has id_uses_rt_i=0 with rt matching → stall_o=0, fwd=0.
- Flush during load-use hazard: flush_i=1 with stall condition present → stall_o=0; bubble in stage 0; next instruction issues normally.
- Reset mid-flight and params: rst_i high with all stages valid → all outputs 0 next cycle. Rerun the load-use test with STAGES=4, LOAD_RESULT_STAGE=2 → 2-cycle stall, then select 3.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// Load-use stall and EX-operand forwarding control for an in-order pipeline.
// A per-stage scoreboard shadows every in-flight register write after decode.
module pipe_hazard_unit #(
  parameter int REG_ADDR_W        = 5,
  parameter int STAGES            = 3,
  parameter int LOAD_RESULT_STAGE = 1,
  parameter int FWD_W             = $clog2(STAGES + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         id_valid_i,
  input  logic [REG_ADDR_W-1:0]        id_rs_i,
  input  logic [REG_ADDR_W-1:0]        id_rt_i,
  input  logic                         id_uses_rs_i,
  input  logic                         id_uses_rt_i,
  input  logic                         id_regwrite_i,
  input  logic [REG_ADDR_W-1:0]        id_rd_i,
  input  logic                         id_memtoreg_i,
  input  logic                         flush_i,
  output logic                         stall_o,
  output logic [FWD_W-1:0]             fwd_rs_o,
  output logic [FWD_W-1:0]             fwd_rt_o,
  output logic [STAGES-1:0]            stage_valid_o,
  output logic [STAGES-1:0]            stage_regwrite_o,
  output logic [STAGES*REG_ADDR_W-1:0] stage_rd_o
);

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rd;
  } entry_t;

  entry_t                stage_q [STAGES];
  entry_t                stage_d [STAGES];
  entry_t                id_entry;
  logic [REG_ADDR_W-1:0] src [2];
  logic [1:0]            src_used;
  logic [1:0]            hazard;
  logic [FWD_W-1:0]      sel_d [2];
  logic [FWD_W-1:0]      fwd_rs_q;
  logic [FWD_W-1:0]      fwd_rt_q;
  logic                  found;
  logic                  issue;

  assign src[0]      = id_rs_i;
  assign src[1]      = id_rt_i;
  assign src_used[0] = id_uses_rs_i;
  assign src_used[1] = id_uses_rt_i;

  // Lowest stage index is the youngest producer, so the first hit wins.
  always_comb begin
    found    = 1'b0;
    hazard   = '0;
    sel_d[0] = '0;
    sel_d[1] = '0;
    for (int o = 0; o < 2; o++) begin
      found = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        if (!found && src_used[o] && (src[o] != '0) && stage_q[k].valid &&
            stage_q[k].regwrite && (stage_q[k].rd == src[o])) begin
          found     = 1'b1;
          hazard[o] = stage_q[k].is_load && (k < LOAD_RESULT_STAGE);
          if (k + 1 < STAGES) sel_d[o] = FWD_W'(k + 1);
        end
      end
    end
  end

  assign stall_o = id_valid_i & ~flush_i & (|hazard);
  assign issue   = id_valid_i & ~flush_i & ~(|hazard);

  // Writes to r0 are recorded as non-writing so r0 can never match.
  assign id_entry.valid    = 1'b1;
  assign id_entry.regwrite = id_regwrite_i & (id_rd_i != '0);
  assign id_entry.is_load  = id_memtoreg_i;
  assign id_entry.rd       = id_rd_i;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_d[gi] = issue ? id_entry : '0;
      end else begin : g_tail
        assign stage_d[gi] = stage_q[gi-1];
      end
      assign stage_valid_o[gi]                             = stage_q[gi].valid;
      assign stage_regwrite_o[gi]                          = stage_q[gi].valid & stage_q[gi].regwrite;
      assign stage_rd_o[gi*REG_ADDR_W +: REG_ADDR_W]       = stage_q[gi].rd;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
      fwd_rs_q <= '0;
      fwd_rt_q <= '0;
    end else if (start_i) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
      fwd_rs_q <= issue ? sel_d[0] : '0;
      fwd_rt_q <= issue ? sel_d[1] : '0;
    end
  end

  assign fwd_rs_o = fwd_rs_q;
  assign fwd_rt_o = fwd_rt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed vector table on the default build,
// a deeper-pipeline load-use sequence, then random traffic against a model.
module tb_pipe_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, idv, urs, urt, rw, ld, fl;
  logic [4:0] rs, rt, rd;

  logic        stall_a, stall_b;
  logic [1:0]  frs_a, frt_a;
  logic [2:0]  frs_b, frt_b;
  logic [2:0]  sv_a, srw_a;
  logic [3:0]  sv_b, srw_b;
  logic [14:0] srd_a;
  logic [19:0] srd_b;

  pipe_hazard_unit dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .id_valid_i(idv),
    .id_rs_i(rs), .id_rt_i(rt), .id_uses_rs_i(urs), .id_uses_rt_i(urt),
    .id_regwrite_i(rw), .id_rd_i(rd), .id_memtoreg_i(ld), .flush_i(fl),
    .stall_o(stall_a), .fwd_rs_o(frs_a), .fwd_rt_o(frt_a),
    .stage_valid_o(sv_a), .stage_regwrite_o(srw_a), .stage_rd_o(srd_a)
  );

  pipe_hazard_unit #(.STAGES(4), .LOAD_RESULT_STAGE(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .id_valid_i(idv),
    .id_rs_i(rs), .id_rt_i(rt), .id_uses_rs_i(urs), .id_uses_rt_i(urt),
    .id_regwrite_i(rw), .id_rd_i(rd), .id_memtoreg_i(ld), .flush_i(fl),
    .stall_o(stall_b), .fwd_rs_o(frs_b), .fwd_rt_o(frt_b),
    .stage_valid_o(sv_b), .stage_regwrite_o(srw_b), .stage_rd_o(srd_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic rst, st, idv;
    logic [4:0] rs; logic urs;
    logic [4:0] rt; logic urt;
    logic [4:0] rd; logic rw, ld, fl;
    logic chk_stall, stl;
    logic [2:0] val, rwx;
    logic [1:0] frs, frt;
  } vec_t;

  function automatic vec_t v(input logic rst_, st_, idv_, input logic [4:0] rs_, input logic urs_,
                             input logic [4:0] rt_, input logic urt_, input logic [4:0] rd_,
                             input logic rw_, ld_, fl_, chk_, stl_, input logic [2:0] val_, rwx_,
                             input logic [1:0] frs_, frt_);
    vec_t r;
    r.rst = rst_; r.st = st_; r.idv = idv_; r.rs = rs_; r.urs = urs_; r.rt = rt_; r.urt = urt_;
    r.rd = rd_; r.rw = rw_; r.ld = ld_; r.fl = fl_; r.chk_stall = chk_; r.stl = stl_;
    r.val = val_; r.rwx = rwx_; r.frs = frs_; r.frt = frt_;
    return r;
  endfunction

  task automatic apply(input vec_t r);
    rst = r.rst; start = r.st; idv = r.idv; rs = r.rs; urs = r.urs; rt = r.rt; urt = r.urt;
    rd = r.rd; rw = r.rw; ld = r.ld; fl = r.fl;
  endtask

  // Issue-time reference model: an instruction issued at advance count t sits in
  // stage (now - t - 1); nothing here mirrors a shift register.
  typedef struct {int d; int t; logic [4:0] rd; logic rw; logic ld;} iss_t;
  iss_t hist[$];
  int now_t[2];
  int ns[2];
  int nl[2];
  int efwd[2][2];

  function automatic int find_at(input int d, input int k);
    for (int i = 0; i < hist.size(); i++)
      if (hist[i].d == d && hist[i].t == now_t[d] - (k + 1)) return i;
    return -1;
  endfunction

  task automatic lookup(input int d, input logic [4:0] src, input logic use_,
                        output int sel, output bit haz);
    int best, age;
    best = -1; sel = 0; haz = 0;
    if (use_ && src != 0) begin
      for (int i = 0; i < hist.size(); i++) begin
        age = now_t[d] - hist[i].t;
        if (hist[i].d == d && age >= 1 && age <= ns[d] && hist[i].rw && hist[i].rd != 0 &&
            hist[i].rd == src && (best < 0 || hist[i].t > hist[best].t)) best = i;
      end
    end
    if (best >= 0) begin
      age = now_t[d] - hist[best].t;
      haz = hist[best].ld && (age - 1 < nl[d]);
      sel = (age < ns[d]) ? age : 0;
    end
  endtask

  task automatic check_state(input int d);
    int idx;
    logic [3:0]  av, arw;
    logic [19:0] ard;
    logic [2:0]  afr, aft;
    av  = (d == 0) ? {1'b0, sv_a}  : sv_b;
    arw = (d == 0) ? {1'b0, srw_a} : srw_b;
    ard = (d == 0) ? {5'd0, srd_a} : srd_b;
    afr = (d == 0) ? {1'b0, frs_a} : frs_b;
    aft = (d == 0) ? {1'b0, frt_a} : frt_b;
    for (int k = 0; k < ns[d]; k++) begin
      idx = find_at(d, k);
      chk($sformatf("rnd_valid d%0d s%0d", d, k), av[k], idx >= 0);
      chk($sformatf("rnd_regwrite d%0d s%0d", d, k), arw[k],
          idx >= 0 && hist[idx].rw && hist[idx].rd != 0);
      chk($sformatf("rnd_rd d%0d s%0d", d, k), ard[k*5 +: 5], (idx >= 0) ? hist[idx].rd : 5'd0);
    end
    chk($sformatf("rnd_fwd_rs d%0d", d), afr, efwd[d][0]);
    chk($sformatf("rnd_fwd_rt d%0d", d), aft, efwd[d][1]);
  endtask

  vec_t tbl[$];

  initial begin
    int  sel_rs[2], sel_rt[2];
    bit  haz_rs, haz_rt, stl_exp[2], iss;
    iss_t e;

    ns[0] = 3; nl[0] = 1; ns[1] = 4; nl[1] = 2;
    now_t[0] = 0; now_t[1] = 0;

    //         rst st idv rs urs rt urt rd rw ld fl chk stl val     rwx     frs frt
    tbl.push_back(v(1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0)); // reset
    tbl.push_back(v(0, 1, 1,  1, 1,  2, 1,  3, 1, 0, 0, 1, 0, 3'b001, 3'b001, 0, 0)); // add r3
    tbl.push_back(v(0, 1, 1,  3, 1,  7, 1,  6, 1, 0, 0, 1, 0, 3'b011, 3'b011, 1, 0)); // sub uses r3
    tbl.push_back(v(0, 1, 1,  9, 1, 10, 1,  8, 1, 0, 0, 1, 0, 3'b111, 3'b111, 0, 0)); // add r8
    tbl.push_back(v(0, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 1, 0, 3'b110, 3'b110, 0, 0)); // gap
    tbl.push_back(v(0, 1, 1, 12, 1,  8, 1, 11, 1, 0, 0, 1, 0, 3'b101, 3'b101, 0, 2)); // r8 one gap
    tbl.push_back(v(0, 1, 1,  0, 0,  0, 0, 13, 1, 0, 0, 1, 0, 3'b011, 3'b011, 0, 0)); // add r13
    tbl.push_back(v(0, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 1, 0, 3'b110, 3'b110, 0, 0));
    tbl.push_back(v(0, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 1, 0, 3'b100, 3'b100, 0, 0));
    tbl.push_back(v(0, 1, 1, 13, 1,  0, 0, 14, 1, 0, 0, 1, 0, 3'b001, 3'b001, 0, 0)); // r13 two gaps
    tbl.push_back(v(0, 1, 1,  1, 1,  0, 0,  4, 1, 1, 0, 1, 0, 3'b011, 3'b011, 0, 0)); // lw r4
    tbl.push_back(v(0, 1, 1,  4, 1,  4, 1,  5, 1, 0, 0, 1, 1, 3'b110, 3'b110, 0, 0)); // load-use
    tbl.push_back(v(0, 1, 1,  4, 1,  4, 1,  5, 1, 0, 0, 1, 0, 3'b101, 3'b101, 2, 2));
    tbl.push_back(v(0, 1, 1,  0, 0,  0, 0,  2, 1, 0, 0, 1, 0, 3'b011, 3'b011, 0, 0)); // add r2
    tbl.push_back(v(0, 1, 1,  1, 1,  0, 0,  2, 1, 1, 0, 1, 0, 3'b111, 3'b111, 0, 0)); // lw r2
    tbl.push_back(v(0, 1, 1,  2, 1,  2, 1,  9, 1, 0, 0, 1, 1, 3'b110, 3'b110, 0, 0)); // priority
    tbl.push_back(v(0, 1, 1,  2, 1,  2, 1,  9, 1, 0, 0, 1, 0, 3'b101, 3'b101, 2, 2));
    tbl.push_back(v(0, 1, 1,  0, 0,  0, 0,  0, 1, 0, 0, 1, 0, 3'b011, 3'b010, 0, 0)); // write r0
    tbl.push_back(v(0, 1, 1,  0, 1,  9, 0, 10, 1, 0, 0, 1, 0, 3'b111, 3'b101, 0, 0)); // r0 / unused rt
    tbl.push_back(v(0, 1, 1,  0, 0,  0, 0,  4, 1, 1, 0, 1, 0, 3'b111, 3'b011, 0, 0)); // lw r4
    tbl.push_back(v(0, 1, 1,  4, 1,  4, 1,  5, 1, 0, 1, 1, 0, 3'b110, 3'b110, 0, 0)); // flush wins
    tbl.push_back(v(0, 1, 1,  4, 1,  1, 1,  7, 1, 0, 0, 1, 0, 3'b101, 3'b101, 2, 0)); // next issues
    tbl.push_back(v(0, 1, 1,  0, 0,  0, 0, 20, 1, 0, 0, 1, 0, 3'b011, 3'b011, 0, 0));
    tbl.push_back(v(0, 1, 1,  0, 0,  0, 0, 21, 1, 0, 0, 1, 0, 3'b111, 3'b111, 0, 0));
    tbl.push_back(v(1, 1, 1,  0, 0,  0, 0, 22, 1, 0, 1, 1, 0, 3'b000, 3'b000, 0, 0)); // reset in flight
    tbl.push_back(v(0, 1, 1,  0, 0,  0, 0,  4, 1, 1, 0, 1, 0, 3'b001, 3'b001, 0, 0)); // lw r4
    tbl.push_back(v(0, 0, 1,  4, 1,  4, 1,  5, 1, 0, 0, 1, 1, 3'b001, 3'b001, 0, 0)); // frozen
    tbl.push_back(v(0, 1, 1,  4, 1,  4, 1,  5, 1, 0, 0, 1, 1, 3'b010, 3'b010, 0, 0));
    tbl.push_back(v(0, 1, 1,  4, 1,  4, 1,  5, 1, 0, 0, 1, 0, 3'b101, 3'b101, 2, 2));
    tbl.push_back(v(0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 1, 0, 3'b101, 3'b101, 2, 2)); // frozen selects

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      #4;
      if (tbl[i].chk_stall) chk($sformatf("vec%0d stall", i), stall_a, tbl[i].stl);
      @(posedge clk); #1;
      chk($sformatf("vec%0d valid", i), sv_a, tbl[i].val);
      chk($sformatf("vec%0d regwrite", i), srw_a, tbl[i].rwx);
      chk($sformatf("vec%0d fwd_rs", i), frs_a, tbl[i].frs);
      chk($sformatf("vec%0d fwd_rt", i), frt_a, tbl[i].frt);
      if (tbl[i].rst) chk($sformatf("vec%0d rd_cleared", i), srd_a, 15'd0);
      $display("vec %0d: stall=%0b valid=%b fwd=%0d/%0d", i, stall_a, sv_a, frs_a, frt_a);
    end

    // Deeper pipeline: load result arrives at the end of stage 2.
    apply(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk("deep reset valid", sv_b, 4'b0000);
    apply(v(0, 1, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    #4 chk("deep lw stall", stall_b, 1'b0);
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      apply(v(0, 1, 1, 4, 1, 4, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      #4 chk($sformatf("deep stall c%0d", c), stall_b, c < 2);
      @(posedge clk); #1;
      $display("deep cycle %0d: stall=%0b valid=%b fwd=%0d/%0d", c, stall_b, sv_b, frs_b, frt_b);
    end
    chk("deep valid", sv_b, 4'b1001);
    chk("deep fwd_rs", frs_b, 3'd3);
    chk("deep fwd_rt", frt_b, 3'd3);

    // Random traffic on both builds against the issue-time model.
    apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    hist.delete();
    efwd[0][0] = 0; efwd[0][1] = 0; efwd[1][0] = 0; efwd[1][1] = 0;
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 99) < 3);
      start = ($urandom_range(0, 9) != 0);
      idv   = ($urandom_range(0, 9) != 0);
      rs    = 5'($urandom_range(0, 7));
      rt    = 5'($urandom_range(0, 7));
      rd    = 5'($urandom_range(0, 7));
      urs   = ($urandom_range(0, 3) != 0);
      urt   = ($urandom_range(0, 3) != 0);
      rw    = ($urandom_range(0, 3) != 0);
      ld    = ($urandom_range(0, 2) == 0);
      fl    = ($urandom_range(0, 9) == 0);
      for (int d = 0; d < 2; d++) begin
        lookup(d, rs, urs, sel_rs[d], haz_rs);
        lookup(d, rt, urt, sel_rt[d], haz_rt);
        stl_exp[d] = idv && !fl && (haz_rs || haz_rt);
      end
      #4;
      chk("rnd stall d0", stall_a, stl_exp[0]);
      chk("rnd stall d1", stall_b, stl_exp[1]);
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          for (int i = hist.size() - 1; i >= 0; i--) if (hist[i].d == d) hist.delete(i);
          efwd[d][0] = 0; efwd[d][1] = 0;
        end else if (start) begin
          iss = idv && !fl && !stl_exp[d];
          if (iss) begin
            e.d = d; e.t = now_t[d]; e.rd = rd; e.rw = rw; e.ld = ld;
            hist.push_back(e);
          end
          efwd[d][0] = iss ? sel_rs[d] : 0;
          efwd[d][1] = iss ? sel_rt[d] : 0;
          now_t[d]++;
          for (int i = hist.size() - 1; i >= 0; i--)
            if (hist[i].d == d && now_t[d] - hist[i].t > ns[d]) hist.delete(i);
        end
        check_state(d);
      end
      $display("rnd %0d: rst=%0b st=%0b stall=%0b/%0b valid=%b/%b", n, rst, start,
               stall_a, stall_b, sv_a, sv_b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
